// File: rtl/grant_lease_controller.sv
// grant_lease_controller: turns a one-hot arbiter grant into a bounded
// resource lease with owner tracking, early release, timeout and guard.
//
// Ports:
//   clk            in   1     clock, rising edge
//   rst            in   1     asynchronous reset, active-high
//   grant_inputs   in   N     one-hot grant from the arbiter
//   release_inputs in   N     per-requester early release request
//   res_en         out  1     resource enabled for owner (high in HOLD)
//   owner_valid    out  1     owner_id is valid (high in HOLD)
//   owner_id       out  ID_W  index of current/last owner
//   lease_expired  out  1     pulse: lease ended by timeout
//   release_done   out  1     pulse: lease ended by owner release
//   grant_dropped  out  1     pulse: nonzero grant ignored (HOLD/GUARD)
//   grant_error    out  1     pulse: multi-hot grant seen in IDLE
module grant_lease_controller #(
    parameter int N            = 3,
    parameter int ID_W         = 2,
    parameter int CNT_W        = 8,
    parameter int LEASE_CYCLES = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    grant_inputs,
    input  logic [N-1:0]    release_inputs,
    output logic            res_en,
    output logic            owner_valid,
    output logic [ID_W-1:0] owner_id,
    output logic            lease_expired,
    output logic            release_done,
    output logic            grant_dropped,
    output logic            grant_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LEASE_M1 = CNT_W'(LEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_M1 =
        (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
    localparam logic GUARD_EN = (GUARD_CYCLES > 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   owner_id_q, owner_id_d;
    logic              res_en_q, res_en_d;
    logic              owner_valid_q, owner_valid_d;
    logic              lease_expired_q, lease_expired_d;
    logic              release_done_q, release_done_d;
    logic              grant_dropped_q, grant_dropped_d;
    logic              grant_error_q, grant_error_d;

    // Grant / release decode
    int unsigned       grant_cnt;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              grant_onehot;
    logic              owner_rel;
    logic              lease_end;

    always_comb begin
        grant_cnt = 0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_inputs[i]) begin
                grant_cnt = grant_cnt + 1;
                grant_idx = ID_W'(i);
            end
        end
        grant_any    = (grant_cnt != 0);
        grant_onehot = (grant_cnt == 1);
    end

    // Only the current owner's release bit counts; others are ignored.
    always_comb begin
        owner_rel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner_id_q == ID_W'(i) && release_inputs[i]) begin
                owner_rel = 1'b1;
            end
        end
    end

    assign lease_end = owner_rel || (cnt_q == '0);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            owner_id_q      <= '0;
            res_en_q        <= 1'b0;
            owner_valid_q   <= 1'b0;
            lease_expired_q <= 1'b0;
            release_done_q  <= 1'b0;
            grant_dropped_q <= 1'b0;
            grant_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_id_q      <= owner_id_d;
            res_en_q        <= res_en_d;
            owner_valid_q   <= owner_valid_d;
            lease_expired_q <= lease_expired_d;
            release_done_q  <= release_done_d;
            grant_dropped_q <= grant_dropped_d;
            grant_error_q   <= grant_error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_id_d = owner_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_onehot) begin
                    state_d    = S_HOLD;
                    cnt_d      = LEASE_M1;
                    owner_id_d = grant_idx;
                end
            end
            S_HOLD: begin
                if (lease_end) begin
                    if (GUARD_EN) begin
                        state_d = S_GUARD;
                        cnt_d   = GUARD_M1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        res_en_d        = (state_d == S_HOLD);
        owner_valid_d   = (state_d == S_HOLD);
        lease_expired_d = 1'b0;
        release_done_d  = 1'b0;
        grant_dropped_d = 1'b0;
        grant_error_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                grant_error_d = grant_any && !grant_onehot;
            end
            S_HOLD: begin
                // Release beats a coincident timeout.
                release_done_d  = owner_rel;
                lease_expired_d = !owner_rel && (cnt_q == '0);
                grant_dropped_d = grant_any;
            end
            S_GUARD: begin
                grant_dropped_d = grant_any;
            end
            default: begin
                grant_error_d = 1'b0;
            end
        endcase
    end

    assign res_en        = res_en_q;
    assign owner_valid   = owner_valid_q;
    assign owner_id      = owner_id_q;
    assign lease_expired = lease_expired_q;
    assign release_done  = release_done_q;
    assign grant_dropped = grant_dropped_q;
    assign grant_error   = grant_error_q;

endmodule

// File: tb/tb_grant_lease_controller.sv
// tb_grant_lease_controller: directed and random stimulus for the
// lease controller, checked against a cycle-count reference model.
module tb_grant_lease_controller;

    localparam int N     = 3;
    localparam int ID_W  = 2;
    localparam int CNT_W = 8;
    localparam int LEASE = 4;
    localparam int GUARD = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    grant;
    logic [N-1:0]    rel;
    logic            res_en;
    logic            owner_valid;
    logic [ID_W-1:0] owner_id;
    logic            lease_expired;
    logic            release_done;
    logic            grant_dropped;
    logic            grant_error;

    grant_lease_controller #(
        .N(N), .ID_W(ID_W), .CNT_W(CNT_W),
        .LEASE_CYCLES(LEASE), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .grant_inputs(grant),
        .release_inputs(rel),
        .res_en(res_en),
        .owner_valid(owner_valid),
        .owner_id(owner_id),
        .lease_expired(lease_expired),
        .release_done(release_done),
        .grant_dropped(grant_dropped),
        .grant_error(grant_error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: remaining lease cycles, remaining guard cycles, owner, pulses.
    int hold_left;
    int guard_left;
    int m_own;
    bit m_exp, m_done, m_drop, m_err;

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        int k = 0;
        for (int i = 0; i < N; i++) if (v[i]) k = i;
        return k;
    endfunction

    task automatic model_reset();
        hold_left  = 0;
        guard_left = 0;
        m_own      = 0;
        m_exp      = 0;
        m_done     = 0;
        m_drop     = 0;
        m_err      = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] g, input logic [N-1:0] r);
        m_exp  = 0;
        m_done = 0;
        m_drop = 0;
        m_err  = 0;
        if (hold_left > 0) begin
            m_drop = (g != 0);
            if (r[m_own]) begin
                m_done     = 1;
                hold_left  = 0;
                guard_left = GUARD;
            end else if (hold_left == 1) begin
                m_exp      = 1;
                hold_left  = 0;
                guard_left = GUARD;
            end else begin
                hold_left--;
            end
        end else if (guard_left > 0) begin
            m_drop = (g != 0);
            guard_left--;
        end else if (ones(g) == 1) begin
            m_own     = idx_of(g);
            hold_left = LEASE;
        end else if (g != 0) begin
            m_err = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string where);
        bit on;
        on = (hold_left > 0);
        chk({where, ".res_en"}, 32'(res_en), 32'(on));
        chk({where, ".owner_valid"}, 32'(owner_valid), 32'(on));
        chk({where, ".owner_id"}, 32'(owner_id), 32'(m_own));
        chk({where, ".lease_expired"}, 32'(lease_expired), 32'(m_exp));
        chk({where, ".release_done"}, 32'(release_done), 32'(m_done));
        chk({where, ".grant_dropped"}, 32'(grant_dropped), 32'(m_drop));
        chk({where, ".grant_error"}, 32'(grant_error), 32'(m_err));
    endtask

    task automatic step(input string where, input logic [N-1:0] g,
                        input logic [N-1:0] r);
        grant = g;
        rel   = r;
        @(posedge clk);
        model_edge(g, r);
        #1;
        chk_all(where);
    endtask

    task automatic drain(input string where);
        repeat (8) step(where, '0, '0);
    endtask

    logic [N-1:0] seq [5];
    int           seq_own [5];

    initial begin
        rst   = 1'b1;
        grant = '0;
        rel   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;
        step("idle", '0, '0);

        // 1. async reset mid-HOLD
        step("t1.grant", 3'b001, '0);
        step("t1.hold", '0, '0);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("t1.async_rst");
        @(posedge clk);
        #1;
        chk_all("t1.rst_held");
        rst = 1'b0;
        step("t1.after", '0, '0);
        step("t1.after", '0, '0);

        // 2. timeout then new owner after guard
        step("t2.grant", 3'b001, '0);
        chk("t2.owner0", 32'(owner_id), 32'd0);
        repeat (5) step("t2.lease", '0, '0);
        step("t2.grant2", 3'b100, '0);
        chk("t2.owner2", 32'(owner_id), 32'd2);
        drain("t2.drain");

        // 3. early release on 2nd HOLD cycle
        step("t3.grant", 3'b010, '0);
        step("t3.hold", '0, '0);
        step("t3.release", '0, 3'b010);
        chk("t3.release_done", 32'(release_done), 32'd1);
        drain("t3.drain");

        // 4. non-owner release ignored
        step("t4.grant", 3'b001, '0);
        repeat (5) step("t4.hold", '0, 3'b110);
        drain("t4.drain");

        // 5. collisions
        step("t5.multihot", 3'b011, '0);
        chk("t5.grant_error", 32'(grant_error), 32'd1);
        step("t5.idle", '0, '0);
        step("t5.grant", 3'b001, '0);
        step("t5.drop", 3'b100, '0);
        chk("t5.owner_kept", 32'(owner_id), 32'd0);
        step("t5.hold", '0, '0);
        step("t5.hold", '0, '0);
        step("t5.rel_on_expiry", 3'b100, 3'b001);
        drain("t5.drain");

        // 6. arbiter grant sequence
        seq[0] = 3'b001; seq_own[0] = 0;
        seq[1] = 3'b010; seq_own[1] = 1;
        seq[2] = 3'b100; seq_own[2] = 2;
        seq[3] = 3'b010; seq_own[3] = 1;
        seq[4] = 3'b001; seq_own[4] = 0;
        for (int k = 0; k < 5; k++) begin
            step("t6.grant", seq[k], '0);
            chk("t6.owner", 32'(owner_id), 32'(seq_own[k]));
            repeat (19) step("t6.wait", '0, '0);
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] g;
            logic [N-1:0] r;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 45) g = '0;
            else if (sel < 85) g = 3'(1 << $urandom_range(0, N - 1));
            else g = 3'($urandom);
            r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : '0;
            step("rand", g, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
